playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
Top-level transport controller for the song_reader / notes_player / beat_generator chain. It turns user button pulses (play/pause, next, prev, dynamics toggle) and song_reader's song_done into the play, song, reader-flush and dtoggle controls. It also keeps a per-song elapsed-beat count for display. It sits between the debounced button block and the song_reader/notes_player pair.

Parameters:
NUM_SONGS, 4, number of songs in ROM; valid song indices 0..NUM_SONGS-1
SONG_W, 2, width of song index; must satisfy 2**SONG_W >= NUM_SONGS
FLUSH_CYCLES, 4, cycles reset_player is held on a song change; must be >= 1
ELAPSED_W, 16, width of elapsed_beats counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
play_button  in  1  one-cycle pulse; toggles play/pause
next_button  in  1  one-cycle pulse; advance to next song
prev_button  in  1  one-cycle pulse; go to previous song
dtoggle_button  in  1  one-cycle pulse; toggle dynamics mode
song_done  in  1  from song_reader; current song finished
beat  in  1  from beat_generator; one-cycle beat tick
play  out  1  play enable to song_reader / notes_player
song  out  SONG_W  selected song index
reset_player  out  1  active-high flush to song_reader/notes_player during song change
dtoggle  out  1  one-cycle pulse to notes_player
dynamics_on  out  1  current dynamics mode level
elapsed_beats  out  ELAPSED_W  beats played in current song
busy  out  1  high while in FLUSH

Behaviour:
- Reset (reset=0, async): state PAUSED, play=0, song=0, reset_player=0, dtoggle=0, dynamics_on=0, elapsed_beats=0, busy=0, flush counter=0, resume flag=0.
- All outputs are registered. Response appears on the cycle after the input event.
- States: PAUSED, PLAYING, FLUSH. play=1 only in PLAYING. reset_player=busy=1 only in FLUSH.
- PAUSED: play_button goes to PLAYING.
- PLAYING: play_button goes to PAUSED. Song index is kept. elapsed_beats is not cleared.
- next_button in PAUSED or PLAYING:
  - song <= (song==NUM_SONGS-1) ? 0 : song+1
  - resume <= (state==PLAYING)
  - enter FLUSH
- prev_button: same as next_button, but song <= (song==0) ? NUM_SONGS-1 : song-1.
- song_done in PLAYING, song < NUM_SONGS-1: song+1, resume=1, enter FLUSH.
- song_done in PLAYING, song == NUM_SONGS-1: song=0, enter FLUSH. resume=0 unless PLAYBACK_LOOP_EN is defined.
- song_done in PAUSED or FLUSH is ignored.
- FLUSH:
  - Lasts exactly FLUSH_CYCLES cycles, counted down from FLUSH_CYCLES-1.
  - Then go to PLAYING if resume=1, else PAUSED.
  - play, next, prev and song_done are all ignored during FLUSH.
- Same-cycle priority: next > prev > song_done > play_button. Lower-priority events in that cycle are dropped.
- dtoggle_button is accepted in any state, including FLUSH. Next cycle: dynamics_on inverts and dtoggle pulses high for exactly 1 cycle.
- elapsed_beats:
  - +1 on beat only while in PLAYING; saturates at all-ones.
  - Cleared to 0 on the cycle FLUSH is entered.
  - A beat coinciding with a transition into FLUSH is not counted.
- Reset asserted mid-FLUSH or mid-song returns everything to reset values immediately, with no extra pulse on dtoggle.

Optional Feature:
PLAYBACK_LOOP_EN
- Defined: finishing the last song wraps to song 0 and keeps playing (resume=1).
- Undefined: finishing the last song wraps to song 0 and lands in PAUSED.
- next/prev wrap-around is identical in both builds.

Decomposition:
- Shared header playback_defs.vh holds:
  - state encodings ST_PAUSED=2'd0, ST_PLAYING=2'd1, ST_FLUSH=2'd2
  - default NUM_SONGS / FLUSH_CYCLES values, also used by the top-level and the bench.
- One sub-module, flush_timer:
  - loadable down-counter with width clog2(FLUSH_CYCLES)
  - start input; done pulse on the last FLUSH cycle
  - same clk/reset convention
- FSM, song index, dynamics and elapsed counter stay in playback_sequencer.

Test Plan:
- Release reset, play_button pulse, then 5 beat pulses -> play=1 the next cycle; elapsed_beats=5; song=0.
- PLAYING song=1, next_button -> next cycle song=2, play=0, reset_player=busy=1 for exactly 4 cycles. Then play=1 and elapsed_beats=0.
- PAUSED song=0, prev_button -> song=3, FLUSH 4 cycles, returns to PAUSED (play=0).
- PLAYING song=3, song_done:
  - without PLAYBACK_LOOP_EN -> song=0, ends PAUSED
  - with PLAYBACK_LOOP_EN -> song=0, ends PLAYING
- Same cycle next_button + play_button + song_done in PLAYING song=0 -> only next acts: song=1, resume=1. dtoggle_button during FLUSH -> dtoggle 1-cycle pulse, dynamics_on=1.
- reset driven low during the 2nd FLUSH cycle -> all outputs immediately at reset values. After release, play_button gives PLAYING with song=0.

Source files
------------

// File: rtl/playback_sequencer_pkg.sv
// Shared types and default sizing for the playback sequencer slice.
// State encodings match the ones the song_reader debug taps expect.
package playback_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_FLUSH   = 2'd2
    } play_state_t;

    localparam int DEFAULT_NUM_SONGS    = 4;
    localparam int DEFAULT_SONG_W       = 2;
    localparam int DEFAULT_FLUSH_CYCLES = 4;
    localparam int DEFAULT_ELAPSED_W    = 16;

    // A one-cycle flush still needs a one-bit counter.
    function automatic int timer_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/flush_timer.sv
// Loadable down-counter that times the song-change flush window.
// done is high during the last cycle of the window.
module flush_timer
    import playback_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int              CNT_W = timer_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             running;

    // Counting starts from FLUSH_CYCLES-1 so the window is exactly FLUSH_CYCLES long.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= LOAD;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0)
                running <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

    assign done = running && (count == '0);

endmodule

// File: rtl/playback_sequencer.sv
// Transport controller: play/pause, song select with reader flush, dynamics toggle, beat count.
// Define PLAYBACK_LOOP_EN to keep playing from song 0 after the last song finishes.
module playback_sequencer
    import playback_sequencer_pkg::*;
#(
    parameter int NUM_SONGS    = DEFAULT_NUM_SONGS,
    parameter int SONG_W       = DEFAULT_SONG_W,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int ELAPSED_W    = DEFAULT_ELAPSED_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_button,
    input  logic                 next_button,
    input  logic                 prev_button,
    input  logic                 dtoggle_button,
    input  logic                 song_done,
    input  logic                 beat,
    output logic                 play,
    output logic [SONG_W-1:0]    song,
    output logic                 reset_player,
    output logic                 dtoggle,
    output logic                 dynamics_on,
    output logic [ELAPSED_W-1:0] elapsed_beats,
    output logic                 busy
);

    localparam logic [SONG_W-1:0]    LAST_SONG   = SONG_W'(NUM_SONGS - 1);
    localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = '1;
`ifdef PLAYBACK_LOOP_EN
    localparam logic LOOP_AT_END = 1'b1;
`else
    localparam logic LOOP_AT_END = 1'b0;
`endif

    play_state_t       state;
    logic              resume;
    logic              flush_done;
    logic              enter_flush;
    logic [SONG_W-1:0] target_song;
    logic              target_resume;

    // Song-change decision; next beats prev beats song_done, and all are blind during FLUSH.
    always_comb begin
        enter_flush   = 1'b0;
        target_song   = song;
        target_resume = resume;
        if (state != ST_FLUSH) begin
            if (next_button) begin
                enter_flush   = 1'b1;
                target_song   = (song == LAST_SONG) ? '0 : song + 1'b1;
                target_resume = (state == ST_PLAYING);
            end else if (prev_button) begin
                enter_flush   = 1'b1;
                target_song   = (song == '0) ? LAST_SONG : song - 1'b1;
                target_resume = (state == ST_PLAYING);
            end else if (song_done && state == ST_PLAYING) begin
                enter_flush = 1'b1;
                if (song == LAST_SONG) begin
                    target_song   = '0;
                    target_resume = LOOP_AT_END;
                end else begin
                    target_song   = song + 1'b1;
                    target_resume = 1'b1;
                end
            end
        end
    end

    flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk  (clk),
        .reset(reset),
        .start(enter_flush),
        .done (flush_done)
    );

    // Main FSM; every output is a register so downstream blocks see clean levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_PAUSED;
            play          <= 1'b0;
            song          <= '0;
            reset_player  <= 1'b0;
            dtoggle       <= 1'b0;
            dynamics_on   <= 1'b0;
            elapsed_beats <= '0;
            busy          <= 1'b0;
            resume        <= 1'b0;
        end else begin
            dtoggle <= dtoggle_button;
            if (dtoggle_button)
                dynamics_on <= ~dynamics_on;

            if (enter_flush) begin
                state         <= ST_FLUSH;
                song          <= target_song;
                resume        <= target_resume;
                play          <= 1'b0;
                reset_player  <= 1'b1;
                busy          <= 1'b1;
                elapsed_beats <= '0;
            end else begin
                case (state)
                    ST_PAUSED: begin
                        if (play_button) begin
                            state <= ST_PLAYING;
                            play  <= 1'b1;
                        end
                    end
                    ST_PLAYING: begin
                        if (beat && elapsed_beats != ELAPSED_MAX)
                            elapsed_beats <= elapsed_beats + 1'b1;
                        if (play_button) begin
                            state <= ST_PAUSED;
                            play  <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_done) begin
                            reset_player <= 1'b0;
                            busy         <= 1'b0;
                            if (resume) begin
                                state <= ST_PLAYING;
                                play  <= 1'b1;
                            end else begin
                                state <= ST_PAUSED;
                            end
                        end
                    end
                    default: begin
                        state        <= ST_PAUSED;
                        play         <= 1'b0;
                        reset_player <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed and randomized bench for playback_sequencer against a cycle-level behavioural model.
// Honors PLAYBACK_LOOP_EN the same way the design does.
module tb_playback_sequencer;
    import playback_sequencer_pkg::*;

    localparam int NUM_SONGS    = DEFAULT_NUM_SONGS;
    localparam int SONG_W       = DEFAULT_SONG_W;
    localparam int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES;
    localparam int ELAPSED_W    = DEFAULT_ELAPSED_W;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 play_button = 1'b0;
    logic                 next_button = 1'b0;
    logic                 prev_button = 1'b0;
    logic                 dtoggle_button = 1'b0;
    logic                 song_done = 1'b0;
    logic                 beat = 1'b0;
    logic                 play;
    logic [SONG_W-1:0]    song;
    logic                 reset_player;
    logic                 dtoggle;
    logic                 dynamics_on;
    logic [ELAPSED_W-1:0] elapsed_beats;
    logic                 busy;

    always #5 clk = ~clk;

    playback_sequencer #(
        .NUM_SONGS(NUM_SONGS),
        .SONG_W(SONG_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .ELAPSED_W(ELAPSED_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .play_button(play_button),
        .next_button(next_button),
        .prev_button(prev_button),
        .dtoggle_button(dtoggle_button),
        .song_done(song_done),
        .beat(beat),
        .play(play),
        .song(song),
        .reset_player(reset_player),
        .dtoggle(dtoggle),
        .dynamics_on(dynamics_on),
        .elapsed_beats(elapsed_beats),
        .busy(busy)
    );

    int compare_count = 0;
    int mismatch_count = 0;

    // Model: mode 0 = paused, 1 = playing, 2 = flushing (m_left cycles remain).
    int m_mode;
    int m_song;
    int m_left;
    int m_elapsed;
    bit m_resume;
    bit m_dyn;
    bit m_dtog;
`ifdef PLAYBACK_LOOP_EN
    bit loop_build = 1'b1;
`else
    bit loop_build = 1'b0;
`endif

    function automatic void model_reset();
        m_mode = 0; m_song = 0; m_left = 0; m_elapsed = 0;
        m_resume = 0; m_dyn = 0; m_dtog = 0;
    endfunction

    function automatic void model_step();
        bit was_playing;
        int new_song;
        bit new_resume;
        if (!reset) begin
            model_reset();
            return;
        end
        m_dtog = dtoggle_button;
        if (dtoggle_button) m_dyn = !m_dyn;
        if (m_mode == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = m_resume ? 1 : 0;
            return;
        end
        was_playing = (m_mode == 1);
        new_song = -1;
        new_resume = 0;
        if (next_button) begin
            new_song = (m_song + 1) % NUM_SONGS;
            new_resume = was_playing;
        end else if (prev_button) begin
            new_song = (m_song + NUM_SONGS - 1) % NUM_SONGS;
            new_resume = was_playing;
        end else if (song_done && was_playing) begin
            new_song = (m_song + 1) % NUM_SONGS;
            new_resume = (m_song + 1 < NUM_SONGS) ? 1'b1 : loop_build;
        end
        if (new_song >= 0) begin
            m_song = new_song; m_resume = new_resume;
            m_mode = 2; m_left = FLUSH_CYCLES; m_elapsed = 0;
        end else begin
            if (was_playing && beat && m_elapsed < (1 << ELAPSED_W) - 1)
                m_elapsed = m_elapsed + 1;
            if (play_button) m_mode = was_playing ? 0 : 1;
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            mismatch_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_output();
        check_val("play", play, m_mode == 1);
        check_val("song", song, m_song);
        check_val("reset_player", reset_player, m_mode == 2);
        check_val("busy", busy, m_mode == 2);
        check_val("dtoggle", dtoggle, m_dtog);
        check_val("dynamics_on", dynamics_on, m_dyn);
        check_val("elapsed_beats", elapsed_beats, m_elapsed);
    endtask

    task automatic apply_stimulus(input bit p, input bit n, input bit pr, input bit dt, input bit d, input bit b);
        @(negedge clk);
        play_button = p; next_button = n; prev_button = pr;
        dtoggle_button = dt; song_done = d; beat = b;
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_output();
        @(negedge clk);
        reset = 1'b1;

        // Play, then five beats.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, 0, 1);
        check_val("elapsed_after_5", elapsed_beats, 32'd5);

        // Next while playing: flush window then resume.
        apply_stimulus(0, 1, 0, 0, 0, 0);
        idle(FLUSH_CYCLES);
        apply_stimulus(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < FLUSH_CYCLES; i++) apply_stimulus(0, 0, 0, 0, 0, 1);
        check_val("song_after_next", song, 32'd2);
        check_val("play_after_flush", play, 32'd1);

        // Paused wrap-around in both directions.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        idle(FLUSH_CYCLES);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        idle(FLUSH_CYCLES);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        idle(FLUSH_CYCLES);
        check_val("prev_wrap_song", song, NUM_SONGS - 1);
        check_val("prev_wrap_paused", play, 32'd0);

        // Last song finishes.
        apply_stimulus(1, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 1);
        idle(FLUSH_CYCLES + 1);
        check_val("end_wrap_song", song, 32'd0);
        check_val("end_wrap_play", play, loop_build);

        // Same-cycle priority, then dynamics toggle inside the flush.
        if (m_mode == 0) apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        check_val("dtoggle_in_flush", dtoggle, 32'd1);
        idle(FLUSH_CYCLES);
        check_val("priority_song", song, 32'd1);
        check_val("priority_resume", play, 32'd1);

        // Reset during the second flush cycle.
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_output();
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        check_output();
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_val("play_after_reset", play, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                           $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
        end
        idle(FLUSH_CYCLES + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
